// File: rtl/usbf_icb_biu_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | usbf_icb_biu_pipe : ICB slave to usbf CSR bridge with response FIFO        |
// | Optional CSR wait timeout enabled by defining USBF_BIU_TIMEOUT_EN          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module usbf_icb_biu_pipe #(
   parameter int            DW             = 32,
   parameter int            AW             = 32,
   parameter int            WIN_BITS       = 12,
   parameter logic [AW-1:0] BASE_ADDR      = 32'h1000_0000,
   parameter int            RSP_DEPTH      = 2,
   parameter int            TIMEOUT_CYCLES = 256
) (
   input  logic            hclk_i,
   input  logic            hrst_i,
   input  logic            icb_cmd_valid_i,
   output logic            icb_cmd_ready_o,
   input  logic [AW-1:0]   icb_cmd_addr_i,
   input  logic            icb_cmd_read_i,
   input  logic [DW-1:0]   icb_cmd_wdata_i,
   input  logic [DW/8-1:0] icb_cmd_wmask_i,
   output logic            icb_rsp_valid_o,
   input  logic            icb_rsp_ready_i,
   output logic [DW-1:0]   icb_rsp_rdata_o,
   output logic            icb_rsp_err_o,
   output logic            csr_wt_en_o,
   output logic            csr_rd_en_o,
   output logic [AW-1:0]   csr_addr_o,
   output logic [DW-1:0]   csr_wdata_o,
   output logic [DW/8-1:0] csr_wmask_o,
   input  logic [DW-1:0]   csr_rdata_i,
   input  logic            csr_ready_i,
   output logic            busy_o
);

   localparam int MW = DW / 8;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0] c_DEPTH    = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] c_PTR_LAST = PW'(RSP_DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   wmask_q;
   logic            read_q;
   logic            hit_q;

   logic [DW-1:0]   mem_rdata_q [RSP_DEPTH];
   logic            mem_err_q   [RSP_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            w_cmd_ready;
   logic            w_accept;
   logic            w_hit;
   logic            w_push;
   logic            w_push_err;
   logic [DW-1:0]   w_push_rdata;
   logic            w_pop;
   logic            w_rd_en;
   logic            w_wt_en;

`ifdef USBF_BIU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]   to_cnt_q;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_hit = (icb_cmd_addr_i[AW-1:WIN_BITS] == BASE_ADDR[AW-1:WIN_BITS]);
   assign w_pop = (cnt_q != '0) && icb_rsp_ready_i;

   always_comb begin
      state_d      = state_q;
      w_cmd_ready  = 1'b0;
      w_accept     = 1'b0;
      w_push       = 1'b0;
      w_push_err   = 1'b0;
      w_push_rdata = '0;
      w_rd_en      = 1'b0;
      w_wt_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Accept only with a free FIFO slot so the eventual push always fits.
            w_cmd_ready = (cnt_q < c_DEPTH);
            if (icb_cmd_valid_i && w_cmd_ready) begin
               w_accept = 1'b1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!hit_q) begin
               w_push     = 1'b1;
               w_push_err = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               w_rd_en = read_q;
               w_wt_en = !read_q;
               if (csr_ready_i) begin
                  w_push       = 1'b1;
                  w_push_rdata = read_q ? csr_rdata_i : '0;
                  state_d      = ST_IDLE;
               end
`ifdef USBF_BIU_TIMEOUT_EN
               else if (to_cnt_q == c_TO_LAST) begin
                  w_push     = 1'b1;
                  w_push_err = 1'b1;
                  state_d    = ST_IDLE;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge hclk_i) begin
      if (hrst_i) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         read_q   <= 1'b0;
         hit_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_accept) begin
            addr_q  <= icb_cmd_addr_i;
            wdata_q <= icb_cmd_wdata_i;
            wmask_q <= icb_cmd_wmask_i;
            read_q  <= icb_cmd_read_i;
            hit_q   <= w_hit;
         end
         if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   // Storage needs no reset: outputs are gated by the FIFO count.
   always_ff @(posedge hclk_i) begin
      if (w_push) begin
         mem_rdata_q[wr_ptr_q] <= w_push_rdata;
         mem_err_q[wr_ptr_q]   <= w_push_err;
      end
   end

`ifdef USBF_BIU_TIMEOUT_EN
   always_ff @(posedge hclk_i) begin
      if (hrst_i) begin
         to_cnt_q <= '0;
      end else if (w_accept) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_ACCESS && !csr_ready_i) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`endif

   assign icb_cmd_ready_o = w_cmd_ready;
   assign icb_rsp_valid_o = (cnt_q != '0);
   assign icb_rsp_rdata_o = icb_rsp_valid_o ? mem_rdata_q[rd_ptr_q] : '0;
   assign icb_rsp_err_o   = icb_rsp_valid_o ? mem_err_q[rd_ptr_q]   : 1'b0;
   assign csr_rd_en_o     = w_rd_en;
   assign csr_wt_en_o     = w_wt_en;
   assign csr_addr_o      = addr_q;
   assign csr_wdata_o     = wdata_q;
   assign csr_wmask_o     = wmask_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usbf_icb_biu_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_usbf_icb_biu_pipe : self-checking bench with CSR register-map model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_usbf_icb_biu_pipe;

   localparam int          DW        = 32;
   localparam int          AW        = 32;
   localparam logic [31:0] BASE      = 32'h1000_0000;
   localparam int          TIMEOUT_C = 8;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic          clk = 1'b0;
   logic          hrst_i = 1'b1;
   logic          icb_cmd_valid_i = 1'b0;
   logic          icb_cmd_ready_o;
   logic [31:0]   icb_cmd_addr_i = '0;
   logic          icb_cmd_read_i = 1'b0;
   logic [31:0]   icb_cmd_wdata_i = '0;
   logic [3:0]    icb_cmd_wmask_i = '0;
   logic          icb_rsp_valid_o;
   logic          icb_rsp_ready_i = 1'b0;
   logic [31:0]   icb_rsp_rdata_o;
   logic          icb_rsp_err_o;
   logic          csr_wt_en_o, csr_rd_en_o;
   logic [31:0]   csr_addr_o, csr_wdata_o;
   logic [3:0]    csr_wmask_o;
   logic [31:0]   csr_rdata_i = '0;
   logic          csr_ready_i = 1'b0;
   logic          busy_o;

   rsp_t          exp_q[$];
   logic [31:0]   regmap [1024];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            rnd_pop  = 0;

   usbf_icb_biu_pipe #(
      .DW(DW), .AW(AW), .WIN_BITS(12), .BASE_ADDR(BASE),
      .RSP_DEPTH(2), .TIMEOUT_CYCLES(TIMEOUT_C)
   ) dut (
      .hclk_i(clk), .hrst_i(hrst_i),
      .icb_cmd_valid_i(icb_cmd_valid_i), .icb_cmd_ready_o(icb_cmd_ready_o),
      .icb_cmd_addr_i(icb_cmd_addr_i), .icb_cmd_read_i(icb_cmd_read_i),
      .icb_cmd_wdata_i(icb_cmd_wdata_i), .icb_cmd_wmask_i(icb_cmd_wmask_i),
      .icb_rsp_valid_o(icb_rsp_valid_o), .icb_rsp_ready_i(icb_rsp_ready_i),
      .icb_rsp_rdata_o(icb_rsp_rdata_o), .icb_rsp_err_o(icb_rsp_err_o),
      .csr_wt_en_o(csr_wt_en_o), .csr_rd_en_o(csr_rd_en_o),
      .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_wmask_o(csr_wmask_o),
      .csr_rdata_i(csr_rdata_i), .csr_ready_i(csr_ready_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!hrst_i) begin
         n_checks++;
         if (csr_rd_en_o === 1'b1 && csr_wt_en_o === 1'b1) begin
            n_fail++;
            $display("FAIL strobe_exclusive rd=1 wt=1 required at most one");
         end
      end
   end

   // Advance one cycle; any response popped at this edge is checked in order.
   task automatic tick();
      rsp_t e;
      if (icb_rsp_valid_o === 1'b1 && icb_rsp_ready_i === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected got err=%0b rdata=%h required none", icb_rsp_err_o, icb_rsp_rdata_o);
         end else begin
            e = exp_q.pop_front();
            if ({icb_rsp_err_o, icb_rsp_rdata_o} !== e) begin
               n_fail++;
               $display("FAIL rsp_data got err=%0b rdata=%h required err=%0b rdata=%h",
                        icb_rsp_err_o, icb_rsp_rdata_o, e.err, e.rdata);
            end
         end
      end
      @(posedge clk);
      #1;
      if (rnd_pop) icb_rsp_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                        input logic [3:0] wm, input int delay, input logic [31:0] rdv);
      int       w;
      logic     hit;
      logic [9:0] idx;
      w   = 0;
      hit = (addr[31:12] == BASE[31:12]);
      idx = addr[11:2];
      while (icb_cmd_ready_o !== 1'b1 && w < 100) begin
         tick();
         w++;
      end
      n_checks++;
      if (icb_cmd_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_wait got=%b required=1 within 100 cycles", icb_cmd_ready_o);
         return;
      end
      icb_cmd_valid_i = 1'b1;
      icb_cmd_addr_i  = addr;
      icb_cmd_read_i  = rd;
      icb_cmd_wdata_i = wd;
      icb_cmd_wmask_i = wm;
      tick();
      icb_cmd_valid_i = 1'b0;
      icb_cmd_addr_i  = $urandom;
      icb_cmd_wdata_i = $urandom;
      if (hit) begin
         for (int k = 0; k <= delay; k++) begin
            n_checks++;
            if ({csr_rd_en_o, csr_wt_en_o, icb_cmd_ready_o, busy_o, csr_addr_o, csr_wdata_o, csr_wmask_o}
                !== {rd, !rd, 1'b0, 1'b1, addr, wd, wm}) begin
               n_fail++;
               $display("FAIL access_cycle%0d got rd=%b wt=%b rdy=%b busy=%b a=%h d=%h m=%h required rd=%b wt=%b rdy=0 busy=1 a=%h d=%h m=%h",
                        k, csr_rd_en_o, csr_wt_en_o, icb_cmd_ready_o, busy_o, csr_addr_o, csr_wdata_o,
                        csr_wmask_o, rd, !rd, addr, wd, wm);
            end
            if (k == delay) begin
               csr_ready_i = 1'b1;
               csr_rdata_i = rdv;
            end
            tick();
            csr_ready_i = 1'b0;
            csr_rdata_i = $urandom;
         end
         exp_q.push_back({1'b0, rd ? rdv : 32'h0});
         if (!rd) begin
            for (int b = 0; b < 4; b++)
               if (wm[b]) regmap[idx][8*b +: 8] = wd[8*b +: 8];
         end
      end else begin
         n_checks++;
         if ({csr_rd_en_o, csr_wt_en_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_strobe got rd=%b wt=%b required 0 0", csr_rd_en_o, csr_wt_en_o);
         end
         tick();
         exp_q.push_back({1'b1, 32'h0});
      end
   endtask

   task automatic test_reset();
      hrst_i = 1'b1;
      repeat (3) tick();
      hrst_i = 1'b0;
      n_checks++;
      if ({icb_rsp_valid_o, icb_cmd_ready_o, csr_rd_en_o, csr_wt_en_o, busy_o, icb_rsp_err_o,
           icb_rsp_rdata_o, csr_addr_o, csr_wdata_o, csr_wmask_o} !== {6'b010000, 100'h0}) begin
         n_fail++;
         $display("FAIL reset_state got v=%b rdy=%b rd=%b wt=%b busy=%b a=%h required rdy=1 rest 0",
                  icb_rsp_valid_o, icb_cmd_ready_o, csr_rd_en_o, csr_wt_en_o, busy_o, csr_addr_o);
      end
      csr_ready_i = 1'b1;
      repeat (2) tick();
      csr_ready_i = 1'b0;
      n_checks++;
      if ({icb_rsp_valid_o, busy_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_ready_ignored got v=%b busy=%b required 0 0", icb_rsp_valid_o, busy_o);
      end
   endtask

   task automatic test_write();
      icb_rsp_ready_i = 1'b0;
      issue(BASE + 32'h10, 1'b0, 32'hA5A5_0001, 4'hF, 0, 32'h0);
      n_checks++;
      if ({icb_rsp_valid_o, icb_rsp_err_o, icb_rsp_rdata_o, csr_wt_en_o, busy_o} !== {2'b10, 32'h0, 2'b00}) begin
         n_fail++;
         $display("FAIL write_latency got v=%b e=%b d=%h wt=%b busy=%b required v=1 e=0 d=0 wt=0 busy=0",
                  icb_rsp_valid_o, icb_rsp_err_o, icb_rsp_rdata_o, csr_wt_en_o, busy_o);
      end
      icb_rsp_ready_i = 1'b1;
      tick();
      icb_rsp_ready_i = 1'b0;
   endtask

   task automatic test_read_wait();
      icb_rsp_ready_i = 1'b1;
      issue(BASE + 32'h04, 1'b1, 32'h0, 4'h0, 5, 32'h1234_5678);
      n_checks++;
      if ({csr_rd_en_o, icb_rsp_valid_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL read_end got rd=%b v=%b required rd=0 v=1", csr_rd_en_o, icb_rsp_valid_o);
      end
      tick();
   endtask

   task automatic test_miss();
      icb_rsp_ready_i = 1'b0;
      issue(BASE + 32'h1000, 1'b1, 32'h0, 4'h0, 0, 32'h0);
      n_checks++;
      if ({icb_rsp_valid_o, icb_rsp_err_o, icb_rsp_rdata_o} !== {2'b11, 32'h0}) begin
         n_fail++;
         $display("FAIL miss_rsp got v=%b e=%b d=%h required v=1 e=1 d=0",
                  icb_rsp_valid_o, icb_rsp_err_o, icb_rsp_rdata_o);
      end
      icb_rsp_ready_i = 1'b1;
      tick();
      icb_rsp_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      icb_rsp_ready_i = 1'b0;
      issue(BASE + 32'h20, 1'b0, 32'h1111_2222, 4'h3, 0, 32'h0);
      issue(BASE + 32'h24, 1'b1, 32'h0, 4'h0, 1, 32'hCAFE_0002);
      n_checks++;
      if ({icb_cmd_ready_o, icb_rsp_valid_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL full_block got rdy=%b v=%b required rdy=0 v=1", icb_cmd_ready_o, icb_rsp_valid_o);
      end
      icb_cmd_valid_i = 1'b1;
      icb_cmd_addr_i  = BASE + 32'h28;
      icb_cmd_read_i  = 1'b1;
      icb_cmd_wdata_i = 32'h0;
      icb_cmd_wmask_i = 4'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({icb_cmd_ready_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL third_held%0d got rdy=%b busy=%b required 0 0", k, icb_cmd_ready_o, busy_o);
         end
      end
      icb_rsp_ready_i = 1'b1;
      tick();
      icb_rsp_ready_i = 1'b0;
      n_checks++;
      if (icb_cmd_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_pop got=%b required=1", icb_cmd_ready_o);
      end
      tick();
      icb_cmd_valid_i = 1'b0;
      n_checks++;
      if (csr_rd_en_o !== 1'b1) begin
         n_fail++;
         $display("FAIL third_strobe got=%b required=1", csr_rd_en_o);
      end
      csr_ready_i     = 1'b1;
      csr_rdata_i     = 32'hBEEF_0003;
      icb_rsp_ready_i = 1'b1;
      exp_q.push_back({1'b0, 32'hBEEF_0003});
      tick();
      csr_ready_i     = 1'b0;
      icb_rsp_ready_i = 1'b0;
      n_checks++;
      if (icb_rsp_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL push_pop_count got v=%b required v=1", icb_rsp_valid_o);
      end
      icb_rsp_ready_i = 1'b1;
      tick();
      icb_rsp_ready_i = 1'b0;
      n_checks++;
      if (icb_rsp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fifo_drained got v=%b required v=0", icb_rsp_valid_o);
      end
   endtask

`ifdef USBF_BIU_TIMEOUT_EN
   task automatic test_timeout();
      icb_rsp_ready_i = 1'b1;
      icb_cmd_valid_i = 1'b1;
      icb_cmd_addr_i  = BASE + 32'h08;
      icb_cmd_read_i  = 1'b1;
      tick();
      icb_cmd_valid_i = 1'b0;
      for (int k = 0; k < TIMEOUT_C; k++) begin
         n_checks++;
         if ({csr_rd_en_o, busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_strobe%0d got rd=%b busy=%b required 1 1", k, csr_rd_en_o, busy_o);
         end
         tick();
      end
      exp_q.push_back({1'b1, 32'h0});
      n_checks++;
      if ({csr_rd_en_o, busy_o, icb_rsp_valid_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL timeout_end got rd=%b busy=%b v=%b required 0 0 1", csr_rd_en_o, busy_o, icb_rsp_valid_o);
      end
      issue(BASE + 32'h08, 1'b1, 32'h0, 4'h0, TIMEOUT_C - 1, 32'h5A5A_0008);
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      icb_rsp_ready_i = 1'b0;
      issue(BASE + 32'h30, 1'b0, 32'h0000_00FF, 4'h1, 0, 32'h0);
      icb_cmd_valid_i = 1'b1;
      icb_cmd_addr_i  = BASE + 32'h34;
      icb_cmd_read_i  = 1'b1;
      tick();
      icb_cmd_valid_i = 1'b0;
      hrst_i = 1'b1;
      tick();
      n_checks++;
      if ({csr_rd_en_o, csr_wt_en_o, icb_rsp_valid_o, icb_cmd_ready_o, busy_o} !== 5'b00010) begin
         n_fail++;
         $display("FAIL reset_mid got rd=%b wt=%b v=%b rdy=%b busy=%b required 0 0 0 1 0",
                  csr_rd_en_o, csr_wt_en_o, icb_rsp_valid_o, icb_cmd_ready_o, busy_o);
      end
      hrst_i = 1'b0;
      exp_q.delete();
      tick();
      n_checks++;
      if ({icb_rsp_valid_o, busy_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_after got v=%b busy=%b required 0 0", icb_rsp_valid_o, busy_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic        rd;
      rnd_pop = 1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            addr = $urandom;
            if (addr[31:12] == BASE[31:12]) addr[20] = ~addr[20];
         end else begin
            addr = BASE | {20'h0, 10'($urandom_range(0, 15)), 2'b00};
         end
         rd = 1'($urandom_range(0, 1));
         issue(addr, rd, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), regmap[addr[11:2]]);
      end
      rnd_pop = 0;
      icb_rsp_ready_i = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
      tick();
      n_checks++;
      if (exp_q.size() != 0 || icb_rsp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drain got pending=%0d v=%b required 0 0", exp_q.size(), icb_rsp_valid_o);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) regmap[i] = $urandom;
      #1;
      test_reset();
      test_write();
      test_read_wait();
      test_miss();
      test_back_to_back();
`ifdef USBF_BIU_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
